uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
Parametrised UART receiver, the successor to the fixed 8N1 receiver. It adds configurable frame format (data bits, parity, stop bits), 3-sample majority filtering, and framing/parity/break/overrun detection. A small output FIFO with a valid/ready handshake sits between the serial pin and the consuming logic, so downstream back-pressure does not lose characters.

Parameters:
CLK_DIV, 10416, clock cycles per bit; legal range 8..65535; timer width is clog2(CLK_DIV).
DATA_BITS, 8, data bits per frame; legal range 5..9; sent LSB first.
PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
FIFO_DEPTH, 4, number of receive FIFO entries; power of two, 2..64.

Ports:
CLK  input  1  system clock; all logic is on the rising edge.
RST  input  1  synchronous, active-high reset.
UART_RX  input  1  asynchronous serial line; idles high.
o_data  output  DATA_BITS  data at the FIFO head.
o_frame_err  output  1  head entry had a stop bit sampled low.
o_parity_err  output  1  head entry failed its parity check; always 0 when PARITY=0.
o_valid  output  1  FIFO is non-empty; head is presented on o_data and the error flags.
i_ready  input  1  consumer accepts the head; a pop occurs when o_valid && i_ready.
o_overrun  output  1  one-cycle pulse: a frame was dropped because the FIFO was full.
o_break  output  1  one-cycle pulse: a break condition was detected.
o_busy  output  1  receiver FSM is not in IDLE.

Behaviour:
- Reset:
  - With RST=1, all outputs are 0 on the next edge: o_valid=0, o_data=0, all flags 0, o_busy=0.
  - FIFO is emptied, FSM goes to IDLE, timer=0.
  - Synchroniser and filter registers load 1 (line idle).
  - RST mid-frame abandons the frame; no partial entry is written.
- Input conditioning:
  - UART_RX passes through a 2-FF synchroniser into a 3-bit shift register.
  - filt = majority of the 3 bits.
  - Pin-to-filt latency is 3–4 cycles.
- Timer:
  - Counts 0..CLK_DIV-1; a "tick" is timer==CLK_DIV-1, after which the timer wraps to 0.
  - Exception: START uses the half-period threshold (CLK_DIV/2)-1, integer division.
- FSM states and transitions:
  - IDLE: timer=0, bit index=0. filt==0 -> START.
  - START: at the half-period threshold, if filt==0 -> DATA with timer=0; else (glitch) -> IDLE, nothing written. All later samples therefore land at mid-bit.
  - DATA: on each tick, shift[idx]<=filt. After DATA_BITS ticks -> PARITY if PARITY!=0, else STOP.
  - PARITY: on tick, capture the parity bit and compute the error.
    - Even mode: error if XOR(data, parity bit) != 0.
    - Odd mode: error if XOR(data, parity bit) != 1.
    - Then -> STOP.
  - STOP: on each tick, sample the stop bit; any stop bit sampled 0 sets frame_err. After STOP_BITS ticks -> COMMIT.
  - COMMIT (one cycle):
    - Break case: data==0, the parity bit (if present) ==0, and frame_err. Pulse o_break, write no entry, go to BRK_WAIT.
    - Otherwise, write {data, frame_err, parity_err} to the FIFO and go to IDLE.
  - BRK_WAIT: stay until filt==1, then -> IDLE.
- Frame timing:
  - Commit occurs on the cycle after the last stop-bit tick.
  - o_valid rises on the cycle after commit when the FIFO was empty.
- FIFO:
  - Read/write pointers are log2(FIFO_DEPTH)+1 bits, so full/empty are unambiguous. Both pointers wrap modulo 2*FIFO_DEPTH.
  - Outputs show the head directly; o_data is meaningful only when o_valid=1.
  - Pop and write in the same cycle are both honoured, including when the FIFO is full. Occupancy is then unchanged and no overrun occurs.
  - Write when full without a pop: the entry is dropped, o_overrun pulses, and existing contents are unchanged.
  - Pop when empty is ignored.
- Line activity: a falling edge during STOP, PARITY or COMMIT is not a start bit. It is recognised only from IDLE.
- Ready: i_ready is don't-care while o_valid=0.

Test Plan:
- CLK_DIV=16, 8N1: send 0xA5 with an ideal bit period -> exactly one entry, o_data=0xA5, both error flags 0; o_valid rises within 16*10+8 cycles of the start edge.
- CLK_DIV=16, PARITY=2: send 0x07 with parity bit 1 -> entry 0x07, parity_err=0. Send 0x07 with parity bit 0 -> entry 0x07, parity_err=1.
- Stop bit driven low for frame 0x3C -> entry 0x3C with frame_err=1. Line held low for 12 bit times -> one o_break pulse, no entry, o_busy stays 1 until the line returns high.
- Start glitch of 4 cycles low, and a single-cycle spike inside a data bit -> the glitch yields no entry and a return to IDLE; the spike does not alter the decoded byte.
- FIFO_DEPTH=4, i_ready=0, send 5 frames 0x01..0x05 -> 4 entries, one o_overrun pulse on the 5th. Then i_ready=1 -> pops 0x01, 0x02, 0x03, 0x04 on consecutive cycles.
- RST asserted at data bit 4 of frame 0x55 -> o_valid=0 and o_busy=0 the next cycle. The following clean frame 0x66 is received correctly.

Source files
------------

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver.
// The serial line is synchronised and majority-filtered. A timer-driven FSM
// samples each bit at mid-period and decodes the frame: configurable data
// bits, optional parity, and one or two stop bits. Completed characters and
// their error flags go into a small FIFO that the consumer drains with a
// valid/ready handshake.
//
// Handshake: o_valid is high whenever the FIFO holds an entry, and the head
// entry is presented on o_data/o_frame_err/o_parity_err. An entry is consumed
// on every rising edge where o_valid && i_ready. i_ready is ignored while
// o_valid is low. A commit into a full FIFO is dropped (o_overrun pulses),
// unless a pop happens in the same cycle.
module uart_rx_param #(
    parameter int CLK_DIV    = 10416,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 UART_RX,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_overrun,
    output logic                 o_break,
    output logic                 o_busy
);

    localparam int TW = $clog2(CLK_DIV);
    localparam int IW = 4;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = DATA_BITS + 2;

    localparam logic [TW-1:0] TICK_AT = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] HALF_AT = TW'((CLK_DIV / 2) - 1);
    localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);
    localparam logic          ODD_MODE  = (PARITY == 1);
    localparam logic          HAS_PAR   = (PARITY != 0);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_DATA     = 3'd2,
        ST_PARITY   = 3'd3,
        ST_STOP     = 3'd4,
        ST_COMMIT   = 3'd5,
        ST_BRK_WAIT = 3'd6
    } state_t;

    // Input conditioning registers
    logic [1:0]           r_sync;
    logic [2:0]           r_filt_sh;
    logic                 w_filt;

    // Receiver FSM registers
    state_t               r_state;
    logic [TW-1:0]        r_timer;
    logic [IW-1:0]        r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_frame_err;
    logic                 r_parity_err;
    logic                 r_par_bit;
    logic                 r_break;
    logic                 w_tick;
    logic                 w_is_break;
    logic                 w_commit;

    // FIFO registers
    logic [EW-1:0]        r_mem [FIFO_DEPTH];
    logic [PW-1:0]        r_wptr;
    logic [PW-1:0]        r_rptr;
    logic                 r_overrun;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;
    logic [EW-1:0]        w_head;

    // Two-flop synchroniser feeding a 3-sample window; idle level is 1
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync    <= 2'b11;
            r_filt_sh <= 3'b111;
        end else begin
            r_sync    <= {r_sync[0], UART_RX};
            r_filt_sh <= {r_filt_sh[1:0], r_sync[1]};
        end
    end

    assign w_filt = (r_filt_sh[0] & r_filt_sh[1]) |
                    (r_filt_sh[0] & r_filt_sh[2]) |
                    (r_filt_sh[1] & r_filt_sh[2]);

    assign w_tick = (r_timer == TICK_AT);

    // An all-zero character with a low stop bit (and a low parity bit, if
    // one is present) is a line break, not data.
    assign w_is_break = (r_shift == '0) && (!HAS_PAR || !r_par_bit) && r_frame_err;
    assign w_commit   = (r_state == ST_COMMIT) && !w_is_break;

    // Frame decoder: bit timing, sampling, error capture and commit
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= ST_IDLE;
            r_timer      <= '0;
            r_idx        <= '0;
            r_shift      <= '0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_par_bit    <= 1'b0;
            r_break      <= 1'b0;
        end else begin
            r_break <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_timer <= '0;
                    r_idx   <= '0;
                    if (!w_filt) begin
                        r_state      <= ST_START;
                        r_frame_err  <= 1'b0;
                        r_parity_err <= 1'b0;
                        r_par_bit    <= 1'b0;
                    end
                end
                ST_START: begin
                    // Re-check the start bit at its middle; this also aligns
                    // every later full-period tick to mid-bit.
                    if (r_timer == HALF_AT) begin
                        r_timer <= '0;
                        r_state <= w_filt ? ST_IDLE : ST_DATA;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        r_timer <= '0;
                        // LSB arrives first, so shift in from the top
                        r_shift <= {w_filt, r_shift[DATA_BITS-1:1]};
                        if (r_idx == LAST_DATA) begin
                            r_idx   <= '0;
                            r_state <= HAS_PAR ? ST_PARITY : ST_STOP;
                        end else begin
                            r_idx <= r_idx + IW'(1);
                        end
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                ST_PARITY: begin
                    if (w_tick) begin
                        r_timer      <= '0;
                        r_par_bit    <= w_filt;
                        r_parity_err <= (^r_shift) ^ w_filt ^ ODD_MODE;
                        r_state      <= ST_STOP;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        r_timer <= '0;
                        if (!w_filt) begin
                            r_frame_err <= 1'b1;
                        end
                        if (r_idx == LAST_STOP) begin
                            r_idx   <= '0;
                            r_state <= ST_COMMIT;
                        end else begin
                            r_idx <= r_idx + IW'(1);
                        end
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                ST_COMMIT: begin
                    r_timer <= '0;
                    if (w_is_break) begin
                        r_break <= 1'b1;
                        r_state <= ST_BRK_WAIT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_BRK_WAIT: begin
                    if (w_filt) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[PW-1] != r_rptr[PW-1]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop   = !w_empty && i_ready;
    assign w_push  = w_commit && (!w_full || w_pop);
    assign w_head  = r_mem[r_rptr[AW-1:0]];

    // FIFO pointers and the overrun pulse for a commit that found no room
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_commit && w_full && !w_pop;
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
        end
    end

    // FIFO storage; contents are only observable through a valid head
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= {r_shift, r_frame_err, r_parity_err};
        end
    end

    assign o_valid      = !w_empty;
    assign o_data       = o_valid ? w_head[EW-1:2] : '0;
    assign o_frame_err  = o_valid ? w_head[1] : 1'b0;
    assign o_parity_err = o_valid ? w_head[0] : 1'b0;
    assign o_overrun    = r_overrun;
    assign o_break      = r_break;
    assign o_busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: one 8N1 receiver and one 8E1 receiver at
// 16 clocks per bit, driven with ideal-timed frames.
module tb_uart_rx_param;

    localparam int CLK_DIV = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_a, rx_b;
    logic       ready_a, ready_b;

    logic [7:0] data_a, data_b;
    logic       fe_a, pe_a, valid_a, ovr_a, brk_a, busy_a;
    logic       fe_b, pe_b, valid_b, ovr_b, brk_b, busy_b;

    int n_tests = 0;
    int n_fail  = 0;

    logic [9:0] exp_q_a[$];
    logic [9:0] exp_q_b[$];

    int ovr_cnt_a = 0, brk_cnt_a = 0;
    int ovr_cnt_b = 0, brk_cnt_b = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    uart_rx_param #(
        .CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) u_dut_a (
        .CLK(clk), .RST(rst), .UART_RX(rx_a),
        .o_data(data_a), .o_frame_err(fe_a), .o_parity_err(pe_a),
        .o_valid(valid_a), .i_ready(ready_a),
        .o_overrun(ovr_a), .o_break(brk_a), .o_busy(busy_a)
    );

    uart_rx_param #(
        .CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) u_dut_b (
        .CLK(clk), .RST(rst), .UART_RX(rx_b),
        .o_data(data_b), .o_frame_err(fe_b), .o_parity_err(pe_b),
        .o_valid(valid_b), .i_ready(ready_b),
        .o_overrun(ovr_b), .o_break(brk_b), .o_busy(busy_b)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard / monitors ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (ovr_a) ovr_cnt_a++;
            if (brk_a) brk_cnt_a++;
            if (valid_a && ready_a) begin
                if (exp_q_a.size() == 0) begin
                    check("a_unexpected_entry_qsize", exp_q_a.size(), 1);
                end else begin
                    check("a_entry", {22'd0, data_a, fe_a, pe_a}, {22'd0, exp_q_a.pop_front()});
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (ovr_b) ovr_cnt_b++;
            if (brk_b) brk_cnt_b++;
            if (valid_b && ready_b) begin
                if (exp_q_b.size() == 0) begin
                    check("b_unexpected_entry_qsize", exp_q_b.size(), 1);
                end else begin
                    check("b_entry", {22'd0, data_b, fe_b, pe_b}, {22'd0, exp_q_b.pop_front()});
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_line(input bit which, input logic v);
        if (which) rx_b = v;
        else       rx_a = v;
    endtask

    // Drive nbits LSB first, one bit period each; spike_bit gets a
    // one-cycle inversion at its middle.
    task automatic send_raw(input bit which, input logic [15:0] bits, input int nbits,
                            input int spike_bit);
        for (int i = 0; i < nbits; i++) begin
            set_line(which, bits[i]);
            if (i == spike_bit) begin
                step(CLK_DIV / 2);
                set_line(which, ~bits[i]);
                step(1);
                set_line(which, bits[i]);
                step(CLK_DIV / 2 - 1);
            end else begin
                step(CLK_DIV);
            end
        end
        set_line(which, 1'b1);
    endtask

    // 8N1 frame on DUT A; a low stop level should come back as frame_err
    task automatic send_a(input logic [7:0] d, input logic stop, input int spike_bit,
                          input bit expect_entry);
        logic [15:0] bits;
        bits = {6'd0, stop, d, 1'b0};
        if (expect_entry) exp_q_a.push_back({d, ~stop, 1'b0});
        send_raw(1'b0, bits, 10, spike_bit);
    endtask

    // 8E1 frame on DUT B with an explicit parity bit
    task automatic send_b(input logic [7:0] d, input logic par);
        logic [15:0] bits;
        bits = {4'd0, 1'b1, par, d, 1'b0};
        exp_q_b.push_back({d, 1'b0, ^{d, par}});
        send_raw(1'b1, bits, 11, -1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int cnt;

        rst     = 1'b1;
        rx_a    = 1'b1;
        rx_b    = 1'b1;
        ready_a = 1'b1;
        ready_b = 1'b1;
        step(3);
        @(negedge clk);
        check("rst_valid_a",   valid_a, 0);
        check("rst_data_a",    data_a,  0);
        check("rst_fe_a",      fe_a,    0);
        check("rst_pe_a",      pe_a,    0);
        check("rst_overrun_a", ovr_a,   0);
        check("rst_break_a",   brk_a,   0);
        check("rst_busy_a",    busy_a,  0);
        check("rst_valid_b",   valid_b, 0);
        check("rst_busy_b",    busy_b,  0);
        step(1);
        rst = 1'b0;
        step(4);

        // Clean 0xA5 with latency bound from the start edge
        cnt = 0;
        fork
            send_a(8'hA5, 1'b1, -1, 1'b1);
            begin
                while (!valid_a && cnt < 400) begin
                    @(negedge clk);
                    if (!valid_a) cnt++;
                end
                check("a5_valid_seen", valid_a, 1);
                check("a5_latency_within_168", (cnt <= 168), 1);
            end
        join
        step(2 * CLK_DIV);

        // Even parity: correct and wrong parity bit
        send_b(8'h07, 1'b1);
        step(2 * CLK_DIV);
        send_b(8'h07, 1'b0);
        step(2 * CLK_DIV);
        send_b(8'hC3, 1'b0);
        step(2 * CLK_DIV);

        // Stop bit low -> frame error entry
        send_a(8'h3C, 1'b0, -1, 1'b1);
        step(2 * CLK_DIV);

        // Break: line low for 12 bit times
        rx_a = 1'b0;
        step(11 * CLK_DIV);
        check("break_busy_held", busy_a, 1);
        check("break_pulse_count", brk_cnt_a, 1);
        step(CLK_DIV);
        rx_a = 1'b1;
        step(12);
        check("break_busy_released", busy_a, 0);
        check("break_pulse_single", brk_cnt_a, 1);
        step(2 * CLK_DIV);

        // Start glitch of 4 cycles
        rx_a = 1'b0;
        step(4);
        rx_a = 1'b1;
        step(3);
        check("glitch_start_busy", busy_a, 1);
        step(CLK_DIV);
        check("glitch_back_idle", busy_a, 0);
        step(CLK_DIV);

        // One-cycle spike inside data bit 3
        send_a(8'h5A, 1'b1, 4, 1'b1);
        step(2 * CLK_DIV);

        // Overrun: 5 back-to-back frames with the consumer stalled
        ready_a = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send_a(8'(i), 1'b1, -1, (i <= 4));
            if (i == 4) check("no_overrun_before_5th", ovr_cnt_a, 0);
        end
        step(2 * CLK_DIV);
        check("overrun_count", ovr_cnt_a, 1);
        check("full_valid", valid_a, 1);
        ready_a = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("drain_4_consecutive", valid_a, 0);
        check("drain_queue_empty", exp_q_a.size(), 0);
        step(2 * CLK_DIV);

        // Reset mid-frame with a stored entry pending
        ready_a = 1'b0;
        send_a(8'h11, 1'b1, -1, 1'b1);
        step(CLK_DIV);
        rx_a = 1'b0;
        step(CLK_DIV);
        for (int k = 0; k < 4; k++) begin
            rx_a = k[0];
            step(CLK_DIV);
        end
        rx_a = 1'b1;
        step(CLK_DIV / 2);
        rst = 1'b1;
        exp_q_a.delete();
        @(posedge clk);
        @(negedge clk);
        check("midrst_valid", valid_a, 0);
        check("midrst_busy", busy_a, 0);
        step(1);
        rst = 1'b0;
        ready_a = 1'b1;
        step(3 * CLK_DIV);
        send_a(8'h66, 1'b1, -1, 1'b1);
        step(3 * CLK_DIV);

        // Final bookkeeping
        check("final_queue_a", exp_q_a.size(), 0);
        check("final_queue_b", exp_q_b.size(), 0);
        check("final_overrun_a", ovr_cnt_a, 1);
        check("final_break_a", brk_cnt_a, 1);
        check("final_overrun_b", ovr_cnt_b, 0);
        check("final_break_b", brk_cnt_b, 0);
        check("final_busy_a", busy_a, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
